// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers for the display UART slice.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int         UART_DATA_BITS = 8;
   localparam logic [7:0] ASCII_LF       = 8'h0A;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and occupancy level.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   // A pop frees the slot this cycle, so a push into a full FIFO still lands.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/display_uart_tx.sv
// Queues display byte changes and sends them as UART 8N1 frames.
// DISPLAY_UART_HEX_ASCII_EN: send each byte as two hex chars plus LF.
module display_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset_i,
   input  logic [7:0]                    display_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   tx_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  prev_q;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        ovf_q, ovf_d;
   logic        push, pop, full, empty, bit_done;
   logic [7:0]  head;
`ifdef DISPLAY_UART_HEX_ASCII_EN
   logic [1:0]  char_q, char_d;
   logic [7:0]  byte_q, byte_d;
`endif

   assign push     = (display_i != prev_q);
   assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_i (reset_i),
      .push_i  (push),
      .data_i  (display_i),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level_o)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE || bit_done) ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef DISPLAY_UART_HEX_ASCII_EN
      char_d  = char_q;
      byte_d  = byte_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = START;
`ifdef DISPLAY_UART_HEX_ASCII_EN
               byte_d  = head;
               char_d  = 2'd0;
               shift_d = hex_ascii(head[7:4]);
`else
               shift_d = head;
`endif
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
               else                                  bit_d   = bit_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
`ifdef DISPLAY_UART_HEX_ASCII_EN
               if (char_q != 2'd2) begin
                  char_d  = char_q + 1'b1;
                  shift_d = (char_q == 2'd0) ? hex_ascii(byte_q[3:0]) : ASCII_LF;
                  state_d = START;
               end else if (!empty) begin
                  pop     = 1'b1;
                  byte_d  = head;
                  char_d  = 2'd0;
                  shift_d = hex_ascii(head[7:4]);
                  state_d = START;
               end else begin
                  char_d  = 2'd0;
                  state_d = IDLE;
               end
`else
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Output bit is registered from the next state so it lines up with it.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE) | (fifo_level_o != '0) | push;
      ovf_d  = ovf_q | (push & full & ~pop);
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         prev_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef DISPLAY_UART_HEX_ASCII_EN
         char_q  <= '0;
         byte_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         prev_q  <= display_i;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
`ifdef DISPLAY_UART_HEX_ASCII_EN
         char_q  <= char_d;
         byte_q  <= byte_d;
`endif
      end
   end

   assign tx_o       = tx_q;
   assign busy_o     = busy_q;
   assign overflow_o = ovf_q;

endmodule
